// File: rtl/countdown_pkg.sv
// Shared types for the countdown display path: controller states, BCD digit type
// and the saturating two-digit BCD decrement.
package countdown_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} cd_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Returns {tens, units} one count lower; 00 saturates rather than wrapping to 99.
    function automatic logic [7:0] bcd_dec(input bcd_t h, input bcd_t l);
        if (l != 4'd0)
            return {h, l - 4'd1};
        else if (h != 4'd0)
            return {h - 4'd1, BCD_MAX};
        else
            return 8'h00;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to one tick per CLK_DIV enabled cycles; the count
// freezes while disabled so a paused step resumes with its phase intact.
module tick_prescaler #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (restart)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown controller: start/pause/clear sequencing, one decrement per
// prescaled tick, done flag when the display reaches 00.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000,
    parameter int INIT_H  = 1,
    parameter int INIT_L  = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic pause,
    input  logic clear,
    output bcd_t TimeH,
    output bcd_t TimeL,
    output logic running,
    output logic done
);

    if (INIT_H > 9 || INIT_L > 9) begin : g_bad_init
        $error("countdown_ctrl: INIT_H/INIT_L must be BCD digits 0..9");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("countdown_ctrl: CLK_DIV must be at least 2");
    end

    localparam bcd_t RELOAD_H  = 4'(INIT_H);
    localparam bcd_t RELOAD_L  = 4'(INIT_L);
    localparam logic INIT_ZERO = (INIT_H == 0) && (INIT_L == 0);

    cd_state_t state;
    logic      tick;
    logic      restart;

    // Fresh runs (from IDLE/DONE) and aborts start the second from zero; resume from
    // PAUSE deliberately does not.
    assign restart = clear || (start && (state == IDLE || state == DONE));

    tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clock   (clock),
        .reset   (reset),
        .enable  (state == RUN),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            TimeH   <= RELOAD_H;
            TimeL   <= RELOAD_L;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            TimeH   <= RELOAD_H;
            TimeL   <= RELOAD_L;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        TimeH <= RELOAD_H;
                        TimeL <= RELOAD_L;
                        if (INIT_ZERO) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state   <= RUN;
                            running <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // start outranks pause, and start means nothing in RUN
                    if (tick) begin
                        {TimeH, TimeL} <= bcd_dec(TimeH, TimeL);
                        if (TimeH == 4'd0 && TimeL <= 4'd1) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else if (pause && !start) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end else if (pause && !start) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (start || pause) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Randomized and directed bench for countdown_ctrl (CLK_DIV=4) against an integer
// countdown model; a second instance built with INIT=00 rides the same stimulus.
module tb_countdown_ctrl;

    localparam int DIV = 4;
    localparam int MS_IDLE = 0, MS_RUN = 1, MS_PAUSE = 2, MS_DONE = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [3:0] th, tl, zh, zl;
    logic run, dn, zrun, zdn;

    always #5 clock = ~clock;

    countdown_ctrl #(.CLK_DIV(DIV), .INIT_H(1), .INIT_L(5)) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .TimeH(th), .TimeL(tl), .running(run), .done(dn));

    countdown_ctrl #(.CLK_DIV(DIV), .INIT_H(0), .INIT_L(0)) dutz (
        .clock(clock), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .TimeH(zh), .TimeL(zl), .running(zrun), .done(zdn));

    // Model: remaining count as a plain integer plus RUN cycles spent in the current step.
    int initv [2] = '{15, 0};
    int mst [2];
    int mval [2];
    int mph [2];

    int ncmp = 0, nbad = 0;
    int lit_req = 0, lit_seen = 0;
    int lit_h, lit_l, lit_r, lit_d, lit_z;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mst[i] = MS_IDLE; mval[i] = initv[i]; mph[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (clear) begin
                mst[i] = MS_IDLE; mval[i] = initv[i]; mph[i] = 0;
            end else if (mst[i] == MS_IDLE || mst[i] == MS_DONE) begin
                if (start) begin
                    mval[i] = initv[i]; mph[i] = 0;
                    mst[i] = (initv[i] == 0) ? MS_DONE : MS_RUN;
                end
            end else if (mst[i] == MS_RUN) begin
                mph[i] = mph[i] + 1;
                if (mph[i] == DIV) begin
                    mph[i] = 0;
                    if (mval[i] > 0) mval[i] = mval[i] - 1;
                    if (mval[i] == 0) mst[i] = MS_DONE;
                end
                if (mst[i] == MS_RUN && pause && !start) mst[i] = MS_PAUSE;
            end else if (mst[i] == MS_PAUSE) begin
                if (start || pause) mst[i] = MS_RUN;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("TimeH", int'(th), mval[0] / 10);
        chk("TimeL", int'(tl), mval[0] % 10);
        chk("running", int'(run), int'(mst[0] == MS_RUN));
        chk("done", int'(dn), int'(mst[0] == MS_DONE));
        chk("z_TimeH", int'(zh), mval[1] / 10);
        chk("z_TimeL", int'(zl), mval[1] % 10);
        chk("z_running", int'(zrun), int'(mst[1] == MS_RUN));
        chk("z_done", int'(zdn), int'(mst[1] == MS_DONE));
        if (lit_req != lit_seen) begin
            lit_seen = lit_req;
            chk("lit_TimeH", int'(th), lit_h);
            chk("lit_TimeL", int'(tl), lit_l);
            chk("lit_running", int'(run), lit_r);
            chk("lit_done", int'(dn), lit_d);
            if (lit_z >= 0) chk("lit_z_done", int'(zdn), lit_z);
        end
    end

    // Hand-computed expectation checked at the next falling edge.
    task automatic lit(input int h, input int l, input int r, input int d, input int z);
        lit_h = h; lit_l = l; lit_r = r; lit_d = d; lit_z = z;
        lit_req++;
    endtask

    // Called just after a rising edge: apply commands for one cycle.
    task automatic cyc(input logic c, input logic s, input logic p);
        clear = c; start = s; pause = p;
        @(posedge clock);
        if (reset) model_step();
        #1;
        clear = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        model_reset();
        lit(1, 5, 0, 0, 0);
        @(negedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        model_reset();
        #2 reset = 1'b0;
        lit(1, 5, 0, 0, 0);
        @(negedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;

        cyc(1'b0, 1'b1, 1'b0); lit(1, 5, 1, 0, 1);
        idle(4);               lit(1, 4, 1, 0, 1);
        idle(4);               lit(1, 3, 1, 0, -1);
        idle(4);               lit(1, 2, 1, 0, -1);
        idle(1);
        cyc(1'b0, 1'b0, 1'b1); lit(1, 2, 0, 0, -1);
        idle(20);              lit(1, 2, 0, 0, -1);
        cyc(1'b0, 1'b0, 1'b1); lit(1, 2, 1, 0, -1);
        idle(1);               lit(1, 2, 1, 0, -1);
        idle(1);               lit(1, 1, 1, 0, -1);
        idle(4);               lit(1, 0, 1, 0, -1);
        idle(4);               lit(0, 9, 1, 0, -1);
        idle(36);              lit(0, 0, 0, 1, -1);
        idle(20);              lit(0, 0, 0, 1, 1);

        cyc(1'b0, 1'b1, 1'b0); lit(1, 5, 1, 0, 1);
        idle(32);              lit(0, 7, 1, 0, -1);
        cyc(1'b1, 1'b1, 1'b0); lit(1, 5, 0, 0, 0);

        cyc(1'b0, 1'b1, 1'b0); lit(1, 5, 1, 0, 1);
        idle(48);              lit(0, 3, 1, 0, -1);
        async_reset();
        cyc(1'b0, 1'b0, 1'b1); lit(1, 5, 0, 0, 0);
        idle(3);               lit(1, 5, 0, 0, 0);

        for (int k = 0; k < 3000; k++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r >= 996)
                async_reset();
            else
                cyc(r < 15, r >= 15 && r < 55, r >= 55 && r < 95);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
